geometry_frame_sequencer: RTL and testbench

Per-frame controller for the geometry engine. Each display frame it starts one geometry pass on vsync and detects pass completion from vertex-output inactivity. It then waits for the rasterizer to drain, performs a framebuffer swap handshake, and advances the animation matrix index every `ANIM_DIV` frames. It sits between the display timing generator, the geometry engine control pins and the rasterizer/framebuffer swap logic.

---
 rtl/geometry_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_geometry_frame_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geometry_frame_sequencer.sv
// Per-frame geometry pass controller: starts a pass on vsync, ends it on vertex inactivity,
// waits for raster drain, runs the framebuffer swap handshake and paces animation steps.
module geometry_frame_sequencer #(
    parameter int IDLE_TIMEOUT = 128,
    parameter int ANIM_DIV     = 4,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_vsync,
    input  logic             i_vertex_fifo_full,
    input  logic             i_vertex_valid,
    input  logic             i_raster_idle,
    input  logic             i_swap_ack,
    output logic             o_geom_enabled,
    output logic             o_geom_start,
    output logic             o_increment_frame,
    output logic             o_swap_req,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_vertex_count,
    output logic [15:0]      o_frame_count,
    output logic             o_overrun,
    output logic [7:0]       o_dropped_frames
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_DRAIN   = 3'd4,
        S_SWAP    = 3'd5,
        S_ADVANCE = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    vtx_cnt_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [ANIM_W-1:0]   anim_cnt_r;
    logic [CNT_W-1:0]    vertex_count_r;
    logic [15:0]         frame_cnt_r;
    logic                geom_enabled_r;
    logic                overrun_r;
    logic [7:0]          dropped_r;
    logic                vsync_miss_s;
    logic                run_timeout_s;

    // A vsync outside IDLE is a missed frame; the pass in flight is left alone.
    assign vsync_miss_s  = i_vsync && (state_r != S_IDLE);
    assign run_timeout_s = !i_vertex_valid && (idle_cnt_r == IDLE_LAST);

    // Next-state decode for the per-frame sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_vsync && i_enable) begin
                    state_next_s = S_ARM;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ARM: begin
                if (i_vertex_fifo_full) begin
                    state_next_s = S_ARM;
                end else begin
                    state_next_s = S_START;
                end
            end
            S_START: begin
                state_next_s = S_RUN;
            end
            S_RUN: begin
                if (run_timeout_s) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (i_raster_idle) begin
                    state_next_s = S_SWAP;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_SWAP: begin
                if (i_swap_ack) begin
                    state_next_s = S_ADVANCE;
                end else begin
                    state_next_s = S_SWAP;
                end
            end
            S_ADVANCE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register plus enable and overrun bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= S_IDLE;
            geom_enabled_r <= 1'b0;
            overrun_r      <= 1'b0;
            dropped_r      <= 8'd0;
        end else begin
            state_r        <= state_next_s;
            geom_enabled_r <= i_enable;
            overrun_r      <= vsync_miss_s;
            if (vsync_miss_s && (dropped_r != 8'hFF)) begin
                dropped_r <= dropped_r + 8'd1;
            end
        end
    end

    // Pass counters: vertex/idle counting during RUN, frame and animation stepping in ADVANCE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vtx_cnt_r      <= {CNT_W{1'b0}};
            idle_cnt_r     <= {IDLE_W{1'b0}};
            anim_cnt_r     <= {ANIM_W{1'b0}};
            vertex_count_r <= {CNT_W{1'b0}};
            frame_cnt_r    <= 16'd0;
        end else begin
            case (state_r)
                S_START: begin
                    vtx_cnt_r  <= {CNT_W{1'b0}};
                    idle_cnt_r <= {IDLE_W{1'b0}};
                end
                S_RUN: begin
                    if (i_vertex_valid) begin
                        idle_cnt_r <= {IDLE_W{1'b0}};
                        if (vtx_cnt_r != {CNT_W{1'b1}}) begin
                            vtx_cnt_r <= vtx_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                    if (run_timeout_s) begin
                        vertex_count_r <= vtx_cnt_r;
                    end
                end
                S_ADVANCE: begin
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                    if (anim_cnt_r == ANIM_LAST) begin
                        anim_cnt_r <= {ANIM_W{1'b0}};
                    end else begin
                        anim_cnt_r <= anim_cnt_r + ANIM_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_geom_enabled    = geom_enabled_r;
    assign o_geom_start      = (state_r == S_START);
    assign o_swap_req        = (state_r == S_SWAP);
    assign o_increment_frame = (state_r == S_ADVANCE) && (anim_cnt_r == ANIM_LAST);
    assign o_busy            = (state_r != S_IDLE);
    assign o_vertex_count    = vertex_count_r;
    assign o_frame_count     = frame_cnt_r;
    assign o_overrun         = overrun_r;
    assign o_dropped_frames  = dropped_r;

endmodule

// File: tb/tb_geometry_frame_sequencer.sv
// Scoreboard bench for geometry_frame_sequencer: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_geometry_frame_sequencer;

    localparam int TO = 16;
    localparam int AD = 2;
    localparam int CW = 16;

    localparam int EV_START = 0;
    localparam int EV_SWAP  = 1;
    localparam int EV_OVR   = 2;
    localparam int EV_FRAME = 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic          i_vsync;
    logic          i_vertex_fifo_full;
    logic          i_vertex_valid;
    logic          i_raster_idle;
    logic          i_swap_ack;
    logic          o_geom_enabled;
    logic          o_geom_start;
    logic          o_increment_frame;
    logic          o_swap_req;
    logic          o_busy;
    logic [CW-1:0] o_vertex_count;
    logic [15:0]   o_frame_count;
    logic          o_overrun;
    logic [7:0]    o_dropped_frames;

    typedef struct {
        int kind;
        int cyc;
        int val;
        int val2;
    } ev_t;

    ev_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    dropped_exp = 0;
    bit    mon_en = 1'b0;
    string kind_name[4] = '{"start", "swap", "ovr", "frame"};

    logic        prev_start = 1'b0;
    logic        prev_swap  = 1'b0;
    logic        prev_inc   = 1'b0;
    logic [15:0] prev_frame = 16'd0;
    int          start_rise = 0;
    int          swap_rise  = 0;
    int          swap_vc    = 0;

    geometry_frame_sequencer #(
        .IDLE_TIMEOUT(TO),
        .ANIM_DIV    (AD),
        .CNT_W       (CW)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_enable          (i_enable),
        .i_vsync           (i_vsync),
        .i_vertex_fifo_full(i_vertex_fifo_full),
        .i_vertex_valid    (i_vertex_valid),
        .i_raster_idle     (i_raster_idle),
        .i_swap_ack        (i_swap_ack),
        .o_geom_enabled    (o_geom_enabled),
        .o_geom_start      (o_geom_start),
        .o_increment_frame (o_increment_frame),
        .o_swap_req        (o_swap_req),
        .o_busy            (o_busy),
        .o_vertex_count    (o_vertex_count),
        .o_frame_count     (o_frame_count),
        .o_overrun         (o_overrun),
        .o_dropped_frames  (o_dropped_frames)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int v, input int v2);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        e.val2 = v2;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int c, input logic [31:0] v, input logic [31:0] v2);
        ev_t e;
        check_eq($sformatf("%s_event_expected", kind_name[kind]), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s_event_kind", kind_name[kind]), kind, e.kind);
            check_eq($sformatf("%s_cycle", kind_name[kind]), c, e.cyc);
            check_eq($sformatf("%s_value", kind_name[kind]), v, e.val);
            check_eq($sformatf("%s_value2", kind_name[kind]), v2, e.val2);
        end
    endtask

    // Output-event monitor: start/swap pulses are reported on their falling edge with their width.
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_geom_start && !prev_start) start_rise <= cyc;
            if (!o_geom_start && prev_start) got_ev(EV_START, start_rise, cyc - start_rise, 0);
            if (o_swap_req && !prev_swap) begin
                swap_rise <= cyc;
                swap_vc   <= int'(o_vertex_count);
            end
            if (!o_swap_req && prev_swap) got_ev(EV_SWAP, swap_rise, cyc - swap_rise, swap_vc);
            if (o_overrun) got_ev(EV_OVR, cyc, o_dropped_frames, 0);
            if (o_frame_count != prev_frame) got_ev(EV_FRAME, cyc, o_frame_count, prev_inc);
            prev_start <= o_geom_start;
            prev_swap  <= o_swap_req;
            prev_inc   <= o_increment_frame;
            prev_frame <= o_frame_count;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic finish_pass(input int exp_frame, input bit exp_inc, input bit ack_vsync);
        int n = 0;
        while (o_swap_req !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("swap_req_seen", n < 200, 1);
        if (n < 200) begin
            tick(2);
            i_swap_ack = 1'b1;
            if (ack_vsync) begin
                i_vsync = 1'b1;
                dropped_exp++;
                push_ev(EV_OVR, cyc + 1, dropped_exp, 0);
            end
            push_ev(EV_FRAME, cyc + 2, exp_frame, exp_inc);
            tick(1);
            i_swap_ack = 1'b0;
            i_vsync    = 1'b0;
            tick(3);
            check_eq("idle_after_pass", o_busy, 0);
            check_eq("frame_count", o_frame_count, exp_frame);
        end
    endtask

    task automatic do_frame(input int n, input int gap, input int exp_frame, input bit exp_inc,
                            input int full_cycles, input int ovr_idx, input bit ack_vsync,
                            input int dis_idx);
        int start_exp;
        int ref_cyc;
        if (full_cycles > 0) begin
            i_vertex_fifo_full = 1'b1;
            i_vsync = 1'b1;
            tick(1);
            i_vsync = 1'b0;
            tick(full_cycles - 1);
            check_eq("arm_hold_busy", o_busy, 1);
            check_eq("arm_hold_no_start", o_geom_start, 0);
            i_vertex_fifo_full = 1'b0;
            start_exp = cyc + 1;
        end else begin
            start_exp = cyc + 2;
            i_vsync = 1'b1;
            tick(1);
            i_vsync = 1'b0;
        end
        push_ev(EV_START, start_exp, 1, 0);
        while (cyc < start_exp + 2) tick(1);
        ref_cyc = start_exp + 1;
        for (int i = 0; i < n; i++) begin
            if (i == ovr_idx) begin
                i_vsync = 1'b1;
                dropped_exp++;
                push_ev(EV_OVR, cyc + 1, dropped_exp, 0);
            end
            if (i == dis_idx) i_enable = 1'b0;
            i_vertex_valid = 1'b1;
            ref_cyc = cyc + 1;
            tick(1);
            i_vertex_valid = 1'b0;
            i_vsync        = 1'b0;
            if (i < n - 1) tick(gap - 1);
        end
        push_ev(EV_SWAP, ref_cyc + 17, 3, n);
        finish_pass(exp_frame, exp_inc, ack_vsync);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        i_rst = 1'b1;
        i_enable = 1'b0;
        i_vsync = 1'b0;
        i_vertex_fifo_full = 1'b0;
        i_vertex_valid = 1'b0;
        i_raster_idle = 1'b1;
        i_swap_ack = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            {i_enable, i_vsync, i_vertex_fifo_full, i_vertex_valid, i_raster_idle, i_swap_ack} = 6'($urandom);
            tick(1);
        end
        i_rst = 1'b0;
        i_enable = 1'b1;
        i_vsync = 1'b0;
        i_vertex_fifo_full = 1'b0;
        i_vertex_valid = 1'b0;
        i_raster_idle = 1'b1;
        i_swap_ack = 1'b0;
        check_eq("rst_geom_enabled", o_geom_enabled, 0);
        check_eq("rst_geom_start", o_geom_start, 0);
        check_eq("rst_increment", o_increment_frame, 0);
        check_eq("rst_swap_req", o_swap_req, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_vertex_count", o_vertex_count, 0);
        check_eq("rst_frame_count", o_frame_count, 0);
        check_eq("rst_overrun", o_overrun, 0);
        check_eq("rst_dropped", o_dropped_frames, 0);
        mon_en = 1'b1;
        tick(1);
        check_eq("geom_enabled_follows", o_geom_enabled, 1);

        // Normal frames; second frame uses a gap landing exactly on the timeout cycle
        do_frame(36, 10, 1, 1'b0, 0, -1, 1'b0, -1);
        check_eq("vertex_count_f1", o_vertex_count, 36);
        do_frame(36, 16, 2, 1'b1, 0, -1, 1'b0, -1);
        check_eq("vertex_count_f2", o_vertex_count, 36);

        // Backpressure
        do_frame(3, 5, 3, 1'b0, 10, -1, 1'b0, -1);

        // Overruns in RUN and in SWAP (together with the ack)
        do_frame(4, 6, 4, 1'b1, 0, 1, 1'b1, -1);
        check_eq("dropped_after_overruns", o_dropped_frames, 2);

        // Vsync while disabled is ignored
        i_enable = 1'b0;
        tick(2);
        check_eq("geom_enabled_low", o_geom_enabled, 0);
        i_vsync = 1'b1;
        tick(1);
        i_vsync = 1'b0;
        tick(1);
        check_eq("disabled_vsync_idle", o_busy, 0);
        tick(20);
        check_eq("disabled_no_drop", o_dropped_frames, dropped_exp);

        // Enable dropped mid-RUN: pass completes, next vsync ignored
        i_enable = 1'b1;
        tick(2);
        do_frame(5, 4, 5, 1'b0, 0, -1, 1'b0, 2);
        i_vsync = 1'b1;
        tick(1);
        i_vsync = 1'b0;
        tick(3);
        check_eq("disabled_after_pass_idle", o_busy, 0);
        i_enable = 1'b1;
        tick(2);

        // Reset during SWAP
        push_ev(EV_START, cyc + 2, 1, 0);
        i_vsync = 1'b1;
        tick(1);
        i_vsync = 1'b0;
        tick(4);
        i_vertex_valid = 1'b1;
        tick(1);
        i_vertex_valid = 1'b0;
        tick(2);
        i_vertex_valid = 1'b1;
        push_ev(EV_SWAP, cyc + 18, 2, 2);
        tick(1);
        i_vertex_valid = 1'b0;
        n = 0;
        while (o_swap_req !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("swap_req_before_reset", n < 200, 1);
        tick(1);
        i_rst = 1'b1;
        push_ev(EV_FRAME, cyc + 1, 0, 0);
        tick(1);
        i_rst = 1'b0;
        dropped_exp = 0;
        check_eq("midrst_swap_req", o_swap_req, 0);
        check_eq("midrst_frame_count", o_frame_count, 0);
        check_eq("midrst_busy", o_busy, 0);
        check_eq("midrst_vertex_count", o_vertex_count, 0);
        check_eq("midrst_dropped", o_dropped_frames, 0);
        tick(2);

        // Zero-vertex pass, then one more to confirm the animation counter restarted
        do_frame(0, 1, 1, 1'b0, 0, -1, 1'b0, -1);
        check_eq("empty_vertex_count", o_vertex_count, 0);
        do_frame(2, 3, 2, 1'b1, 0, -1, 1'b0, -1);

        tick(5);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
